// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-stream instruction memory loader with checksum and CPU hold
module im_loader #(
  parameter int IW = 15,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [9:0] MAX_N = 10'(1 << AW);

  logic [2:0]  state;
  logic [7:0]  hi;
  logic [7:0]  sum;
  logic [8:0]  rem;
  logic        xfer;
  logic [15:0] word;

  assign xfer = in_valid && in_ready;
  assign word = {hi, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      hi           <= 8'd0;
      sum          <= 8'd0;
      rem          <= 9'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_COUNT;
            in_ready     <= 1'b1;
            im_addr      <= '0;
            words_loaded <= '0;
            sum          <= 8'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            rem <= {1'b0, in_data};
            sum <= in_data;
            if ({2'b00, in_data} > MAX_N) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else if (in_data == 8'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi    <= in_data;
            sum   <= sum + in_data;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            sum      <= sum + in_data;
            in_ready <= 1'b0;
            // Bits above IW mean the image was built for a wider memory
            if ((word >> IW) != 16'd0) begin
              state <= S_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              im_wdata <= word[IW-1:0];
              im_we    <= 1'b1;
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          im_we        <= 1'b0;
          im_addr      <= im_addr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
          rem          <= rem - 9'd1;
          in_ready     <= 1'b1;
          state        <= (rem == 9'd1) ? S_CHECK : S_HI;
        end
        S_CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == sum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          im_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake and writes it word-by-word into the instruction memory the CPU fetches from.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-verified image is written.
- Replaces the simulation-only memory preload path, so the same image format works on hardware.

Parameters:
- IW, 15, instruction word width in bits (1..16); each word is sent as 2 bytes, MSB first.
- AW, 8, instruction memory address width (1..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- im_we  output  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  output  AW  write address.
- im_wdata  output  IW  write data.
- cpu_hold  output  1  CPU reset request.
- busy  output  1  load in progress.
- done  output  1  last load succeeded (level).
- error  output  1  last load failed (level).
- words_loaded  output  AW+1  words written in the current or last load.

Behaviour:
- Stream format: count byte N, then N words as 2 bytes each (hi, lo), then check byte C.
- A byte transfers when in_valid && in_ready on a rising clk edge.
- Reset (async): state IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, busy=0, done=0, error=0, words_loaded=0.
- All outputs are registered.
- IDLE: in_ready=0, cpu_hold=1. On start, go to COUNT: addr=0, words_loaded=0, sum=0, done=0, error=0, busy=1.
- COUNT: in_ready=1. On transfer, latch rem=N and set sum=N.
  - N > 2^AW: go to ERR.
  - N == 0: go to CHECK.
  - Otherwise: go to HI.
- HI: in_ready=1. On transfer, latch hi and add the byte to sum; go to LO.
- LO: in_ready=1. On transfer, add the byte to sum.
  - If any bit of {hi,lo} at position >= IW is set: go to ERR; no write occurs.
  - Otherwise: im_wdata={hi,lo}[IW-1:0]; go to WRITE.
- WRITE (exactly 1 cycle): in_ready=0, im_we=1 at the current im_addr.
  - The write occurs one cycle after the lo byte transfers.
  - Next edge: im_addr+=1 (wraps modulo 2^AW only after the final word), words_loaded+=1, rem-=1.
  - rem becomes 0: go to CHECK; otherwise go to HI.
- CHECK: in_ready=1. On transfer: if byte == sum[7:0] go to DONE, else go to ERR.
  - sum is the mod-256 sum of the count byte and all word bytes.
- DONE: busy=0, done=1, cpu_hold=0 (registered; deasserts on the edge entering DONE).
- ERR: busy=0, error=1, cpu_hold=1. Memory contents already written are left as-is.
- DONE and ERR hold until start or rst.
- start while busy: ignored.
- start in DONE: reasserts cpu_hold in the same edge that enters COUNT.
- in_valid without start in IDLE, DONE or ERR: no transfer (in_ready=0).
- Backpressure and gaps: any number of in_valid=0 cycles between bytes are permitted, with no timeout. A stalled state holds all registers.
- rst mid-load: immediate return to reset values; a partially written image stays in memory, and cpu_hold=1 keeps the CPU off it.
- im_we is never asserted outside WRITE; at most one write per word.

Test Plan:
- Load N=3: bytes 03,00,2A,00,7B,41,05, check=EE. Required:
  - Writes occur at addr 0,1,2 with data 0x002A, 0x007B, 0x4105.
  - im_we is high 1 cycle each.
  - done=1, cpu_hold falls, words_loaded=3.
- N=0 with check byte 00 -> no im_we, done=1, cpu_hold=0. Same stream with check 01 -> error=1, cpu_hold=1.
- IW=15, word bytes 80,01 -> error=1 immediately after the lo byte, no im_we, words_loaded=0. Wrong check byte on a valid 1-word image -> word is written, then error=1.
- Random in_valid gaps (0-5 idle cycles) on the N=3 image -> identical writes and done. in_ready=0 during each WRITE cycle, and no byte is lost or duplicated.
- start pulses during HI and LO -> ignored. rst asserted after the second word -> all outputs return to reset values within the same cycle, with no further im_we. A subsequent full load then succeeds from addr 0.
- Two back-to-back loads with start issued in DONE -> cpu_hold reasserts, done clears, and the second image overwrites from addr 0.
